c_bus_writeback: RTL
====================

// Module: c_bus_writeback
// PURPOSE
//  Write-back end of the register bus: accepts a result word from the C bus with a
//  destination code taken from RG1, RG2 or MUX2D, queues it, then drives a one-hot
//  load-enable vector plus write data to the register bank (R1..R14, TOTR, TR, PC, AR,
//  MDDR, AC, MIDR). It is the writer counterpart of the A-bus read mux; same code map.
// PARAMETERS
//  DATA_W   16  width of C bus / register data
//  CODE_W    5  width of destination register code
//  DEPTH     2  write queue entries; power of two, >= 2
// PORTS
//  Clock      in   1         rising-edge clock
//  Reset_n    in   1         asynchronous, active-low reset
//  C_BUS_in   in   DATA_W    result word to write back
//  RG1_out    in   CODE_W    destination code from RG1
//  RG2_out    in   CODE_W    destination code from RG2
//  MUX2D_out  in   CODE_W    destination code from microcode field
//  MUX2S      in   2         dest source: 0 none, 1 RG1, 2 MUX2D, 3 RG2
//  wr_valid   in   1         write request valid
//  wr_ready   out  1         queue can accept (= !full)
//  stall_in   in   1         register bank busy; hold queue head
//  LD_en      out  22        one-hot load enable, bit index = dest code
//  W_out      out  DATA_W    data for the enabled register
//  err_out    out  1         one-cycle pulse: invalid dest code rejected
//  pending    out  log2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Code map: 1..14 R1..R14, 15 TOTR, 16 TR, 17 PC, 18 AR, 19 MDDR, 20 AC, 21 MIDR.
//    Codes 0 and 22..31 invalid.
//  - Reset (Reset_n=0, async): queue flushed, pending=0, LD_en=0, W_out=0, err_out=0,
//    wr_ready=1 after release. Reset mid-operation discards all queued writes.
//  - Accept on rising edge with wr_valid & wr_ready. Code sampled from source selected
//    by MUX2S at that edge, together with C_BUS_in.
//  - MUX2S=0 accepted: silently discarded, no push, no err. Invalid code: no push,
//    err_out=1 for the next cycle only.
//  - Drain: on each edge with queue non-empty and stall_in=0, pop head; LD_en gets that
//    code's one-hot bit and W_out its data for exactly one cycle; otherwise LD_en=0 and
//    W_out holds last value. Never more than one LD_en bit set.
//  - Latency: accept at edge N into empty queue, stall_in=0 -> LD_en pulse after edge N+1.
//  - FIFO order strict. Simultaneous push and pop allowed; pending unchanged.
//  - Full: wr_ready=0 (decided from registered count only; no same-cycle pass-through);
//    wr_valid while full is ignored, not an error.
//  - stall_in=1: head held, LD_en=0, accepts continue until full.
//  - Pointers wrap modulo DEPTH; pending saturates at DEPTH by construction.
// CONFIGURATION
//  WB_PC_PROTECT_EN defined: code 17 (PC) treated as invalid at acceptance -> no push,
//  err_out pulse; PC only writable via its own path. Undefined: PC writes like any other
//  register (LD_en[17]).
// TESTING
//  1 Reset_n low mid-queue (pending=2) -> pending=0, LD_en=0, W_out=0 immediately.
//  2 MUX2S=1, RG1_out=5, C_BUS_in=16'hA5A5 -> next cycle LD_en=1<<5, W_out=16'hA5A5.
//  3 stall_in=1, push codes 3,20,(3rd) -> wr_ready=0 after 2; release -> LD_en bits 3
//    then 20 on consecutive cycles, 3rd request never written.
//  4 MUX2S=3, RG2_out=22 -> err_out one cycle, pending stays 0, no LD_en.
//  5 Push/pop same edge at pending=1 (stall 0) -> pending stays 1, order preserved.
//  6 MUX2S=2, MUX2D_out=17, data 16'h0040 -> LD_en[17] without macro; err_out, no
//    LD_en with WB_PC_PROTECT_EN.

Source files
------------

// File: rtl/c_bus_writeback_if.sv
// C-bus write-back interface: result word, destination-code sources, handshake,
// and the register-bank load-enable/data outputs. The master side is the
// producer and bank; the slave side is the write-back queue.
interface c_bus_writeback_if #(
   parameter int DATA_W = 16,
   parameter int CODE_W = 5,
   parameter int DEPTH  = 2
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] C_BUS_in;
   logic [CODE_W-1:0] RG1_out;
   logic [CODE_W-1:0] RG2_out;
   logic [CODE_W-1:0] MUX2D_out;
   logic [1:0]        MUX2S;
   logic              wr_valid;
   logic              wr_ready;
   logic              stall_in;
   logic [21:0]       LD_en;
   logic [DATA_W-1:0] W_out;
   logic              err_out;
   logic [CNT_W-1:0]  pending;

   modport master (
      output C_BUS_in, RG1_out, RG2_out, MUX2D_out, MUX2S, wr_valid, stall_in,
      input  wr_ready, LD_en, W_out, err_out, pending
   );

   modport slave (
      input  C_BUS_in, RG1_out, RG2_out, MUX2D_out, MUX2S, wr_valid, stall_in,
      output wr_ready, LD_en, W_out, err_out, pending
   );
endinterface

// File: rtl/c_bus_writeback.sv
// Write-back end of the register bus. Takes a result word plus a destination code
// (from RG1, RG2 or MUX2D), queues it in a small FIFO and drains one entry per
// cycle as a one-hot load enable plus data for the register bank.
// Optional macro WB_PC_PROTECT_EN: code 17 (PC) is rejected at acceptance like an
// invalid code, leaving PC writable only through its dedicated path.
module c_bus_writeback #(
   parameter int DATA_W = 16,
   parameter int CODE_W = 5,
   parameter int DEPTH  = 2
) (
   input logic             Clock,
   input logic             Reset_n,
   c_bus_writeback_if.slave bus
);
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int NUM_REGS = 22;
   localparam logic [CODE_W-1:0] CODE_PC = CODE_W'(17);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [CODE_W-1:0] code_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   logic [CODE_W-1:0] sel_code;
   logic              code_ok;
   logic              accept, push, reject, pop;

   // Pick the destination code from the source MUX2S selects (0 = no destination).
   always_comb begin
      sel_code = '0;
      case (bus.MUX2S)
         2'd1:    sel_code = bus.RG1_out;
         2'd2:    sel_code = bus.MUX2D_out;
         2'd3:    sel_code = bus.RG2_out;
         default: sel_code = '0;
      endcase
   end

`ifdef WB_PC_PROTECT_EN
   assign code_ok = (sel_code != '0) && (sel_code < CODE_W'(NUM_REGS)) && (sel_code != CODE_PC);
`else
   assign code_ok = (sel_code != '0) && (sel_code < CODE_W'(NUM_REGS));
`endif

   // Ready is taken from the registered count only, so a full queue never
   // accepts even when the head is leaving on the same edge.
   assign bus.wr_ready = (count != CNT_W'(DEPTH));
   assign bus.pending  = count;

   assign accept = bus.wr_valid && bus.wr_ready;
   assign push   = accept && (bus.MUX2S != 2'd0) && code_ok;
   assign reject = accept && (bus.MUX2S != 2'd0) && !code_ok;
   assign pop    = (count != '0) && !bus.stall_in;

   // Queue storage; contents are meaningless outside [rd_ptr, wr_ptr) so no reset.
   always_ff @(posedge Clock) begin
      if (push) begin
         data_q[wr_ptr] <= bus.C_BUS_in;
         code_q[wr_ptr] <= sel_code;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is 2^n.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Registered bank outputs: one-cycle load pulse per pop, data held between pops,
   // error pulse for a rejected destination code.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.LD_en   <= '0;
         bus.W_out   <= '0;
         bus.err_out <= 1'b0;
      end else begin
         bus.err_out <= reject;
         if (pop) begin
            bus.LD_en <= 22'd1 << code_q[rd_ptr];
            bus.W_out <= data_q[rd_ptr];
         end else begin
            bus.LD_en <= '0;
         end
      end
   end
endmodule
